// File: rtl/shared_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
//   FIFO_WIDTH / FIFO_DEPTH : default data width and entry count
//   fifo_mode_e             : standard (registered) or first-word-fall-through read mode
//   count_width()           : bits needed to hold an occupancy of 0..depth
//   ptr_width()             : bits needed to address depth entries
package shared_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: DEPTH x DATA_WIDTH, synchronous write port, asynchronous read port.
//   clk   : clock
//   we    : write enable
//   waddr : write address (0..DEPTH-1)
//   wdata : write data
//   raddr : read address (0..DEPTH-1)
//   rdata : read data, combinational from raddr
// Contents are deliberately not reset.
module fifo_mem
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int PW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty margins,
// occupancy count, synchronous flush and standard / first-word-fall-through read mode.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : synchronous clear of pointers/count/status (storage untouched)
//   wr_en/data_in: write request and data
//   rd_en        : read (pop) request
//   data_out     : read data (registered in standard mode, head entry in FWFT mode)
//   wr_ack       : previous cycle's write was accepted
//   overflow     : previous cycle's write was rejected because the FIFO was full
//   underflow    : previous cycle's read was rejected because the FIFO was empty
//   full, almostfull, empty, almostempty : combinational from count
//   count        : occupancy 0..DEPTH
module param_sync_fifo
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int FWFT       = 0,
  localparam int CW        = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int              PW       = ptr_width(DEPTH);
  localparam fifo_mode_e      MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_AF   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0]   CNT_AE   = CW'(AE_MARGIN);
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("param_sync_fifo: DEPTH must be >= 2");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_af
      $error("param_sync_fifo: AF_MARGIN must be in 1..DEPTH-1");
    end
    if (AE_MARGIN < 1 || AE_MARGIN > DEPTH - 1) begin : g_bad_ae
      $error("param_sync_fifo: AE_MARGIN must be in 1..DEPTH-1");
    end
  endgenerate

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  do_wr;
  logic                  do_rd;
  logic                  mem_we;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count_r == CNT_FULL);
  assign empty       = (count_r == '0);
  assign almostfull  = !full && (count_r >= CNT_AF);
  assign almostempty = !empty && (count_r <= CNT_AE);
  assign count       = count_r;

  // Acceptance is decided from pre-edge flags, so a full FIFO can still pop
  // and an empty FIFO can still push in the same cycle.
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign mem_we = do_wr && !rst && !flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_wr, do_rd})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      wr_ack    <= do_wr;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign data_out = empty ? '0 : rd_data;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_r;

      // Flush leaves the last read word visible; only reset clears it.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_r <= '0;
        end else if (!flush && do_rd) begin
          dout_r <= rd_data;
        end
      end

      assign data_out = dout_r;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_in = '0;

  always #5 clk = ~clk;

  // DUT A: DEPTH=8, standard read
  logic [15:0] a_data_out;
  logic        a_wr_ack, a_overflow, a_underflow, a_full, a_almostfull, a_empty, a_almostempty;
  logic [3:0]  a_count;

  // DUT B: DEPTH=5, margins 2/2, standard read
  logic [15:0] b_data_out;
  logic        b_wr_ack, b_overflow, b_underflow, b_full, b_almostfull, b_empty, b_almostempty;
  logic [2:0]  b_count;

  // DUT C: DEPTH=8, FWFT
  logic [15:0] c_data_out;
  logic        c_wr_ack, c_overflow, c_underflow, c_full, c_almostfull, c_empty, c_almostempty;
  logic [3:0]  c_count;

  param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(a_data_out), .wr_ack(a_wr_ack), .overflow(a_overflow), .underflow(a_underflow),
    .full(a_full), .almostfull(a_almostfull), .empty(a_empty), .almostempty(a_almostempty),
    .count(a_count));

  param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(b_data_out), .wr_ack(b_wr_ack), .overflow(b_overflow), .underflow(b_underflow),
    .full(b_full), .almostfull(b_almostfull), .empty(b_empty), .almostempty(b_almostempty),
    .count(b_count));

  param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(c_data_out), .wr_ack(c_wr_ack), .overflow(c_overflow), .underflow(c_underflow),
    .full(c_full), .almostfull(c_almostfull), .empty(c_empty), .almostempty(c_almostempty),
    .count(c_count));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic w, input logic rd,
                      input logic [15:0] d);
    rst = r; flush = f; wr_en = w; rd_en = rd; data_in = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, flush, wr, rd;
    logic [15:0] din;
    logic [15:0] dout;
    logic        ack, ovf, udf;
    logic [3:0]  cnt;
    logic        full, af, em, ae;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic w, input logic rd,
                              input logic [15:0] din, input logic [15:0] dout,
                              input logic ack, input logic ovf, input logic udf,
                              input logic [3:0] cnt, input logic full, input logic af,
                              input logic em, input logic ae);
    vec_t v;
    v.rst = r; v.flush = f; v.wr = w; v.rd = rd; v.din = din; v.dout = dout;
    v.ack = ack; v.ovf = ovf; v.udf = udf; v.cnt = cnt;
    v.full = full; v.af = af; v.em = em; v.ae = ae;
    return v;
  endfunction

  vec_t        vt[$];
  logic [15:0] q[$];

  initial begin
    // ---------------- table for DUT A (DEPTH=8, standard) ----------------
    vt.push_back(mk(1,0,0,0,16'h0000, 16'h0000,0,0,0,4'd0, 0,0,1,0));
    for (int i = 1; i <= 8; i++)
      vt.push_back(mk(0,0,1,0,16'(i), 16'h0000,1,0,0,4'(i), i==8, i==7, 0, i==1));
    vt.push_back(mk(0,0,1,0,16'h0009, 16'h0000,0,1,0,4'd8, 1,0,0,0));
    vt.push_back(mk(0,0,1,1,16'h00AA, 16'h0001,0,1,0,4'd7, 0,1,0,0));
    for (int j = 2; j <= 8; j++)
      vt.push_back(mk(0,0,0,1,16'h0000, 16'(j),0,0,0,4'(8-j), 0,0, j==8, j==7));
    vt.push_back(mk(0,0,0,1,16'h0000, 16'h0008,0,0,1,4'd0, 0,0,1,0));
    vt.push_back(mk(0,0,1,1,16'h0042, 16'h0008,1,0,1,4'd1, 0,0,0,1));
    vt.push_back(mk(0,0,0,1,16'h0000, 16'h0042,0,0,0,4'd0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,16'h0000, 16'h0042,0,0,0,4'd0, 0,0,1,0));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(0,0,1,0,16'(16+k), 16'h0042,1,0,0,4'(k+1), 0,0,0, k==0));
    vt.push_back(mk(0,1,1,1,16'h0099, 16'h0042,0,0,0,4'd0, 0,0,1,0));
    vt.push_back(mk(0,0,0,1,16'h0000, 16'h0042,0,0,1,4'd0, 0,0,1,0));
    vt.push_back(mk(0,0,1,0,16'h0055, 16'h0042,1,0,0,4'd1, 0,0,0,1));
    vt.push_back(mk(0,0,0,1,16'h0000, 16'h0055,0,0,0,4'd0, 0,0,1,0));
    vt.push_back(mk(0,0,1,0,16'h0066, 16'h0055,1,0,0,4'd1, 0,0,0,1));
    vt.push_back(mk(0,0,1,0,16'h0077, 16'h0055,1,0,0,4'd2, 0,0,0,0));
    vt.push_back(mk(1,0,1,1,16'h0088, 16'h0000,0,0,0,4'd0, 0,0,1,0));

    #2;
    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].flush, vt[i].wr, vt[i].rd, vt[i].din);
      chk($sformatf("v%0d_dout", i),  32'(a_data_out),    32'(vt[i].dout));
      chk($sformatf("v%0d_ack", i),   32'(a_wr_ack),      32'(vt[i].ack));
      chk($sformatf("v%0d_ovf", i),   32'(a_overflow),    32'(vt[i].ovf));
      chk($sformatf("v%0d_udf", i),   32'(a_underflow),   32'(vt[i].udf));
      chk($sformatf("v%0d_cnt", i),   32'(a_count),       32'(vt[i].cnt));
      chk($sformatf("v%0d_full", i),  32'(a_full),        32'(vt[i].full));
      chk($sformatf("v%0d_af", i),    32'(a_almostfull),  32'(vt[i].af));
      chk($sformatf("v%0d_empty", i), 32'(a_empty),       32'(vt[i].em));
      chk($sformatf("v%0d_ae", i),    32'(a_almostempty), 32'(vt[i].ae));
    end

    // ---------------- DUT B: DEPTH=5, margins 2/2 ----------------
    step(1,0,0,0,16'h0000);
    q.delete();
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin
        step(0,0,1,0,16'(32'h200 + c - 1));
        q.push_back(16'(32'h200 + c - 1));
      end
      chk($sformatf("b_fill%0d_cnt", c),   32'(b_count),       32'(c));
      chk($sformatf("b_fill%0d_empty", c), 32'(b_empty),       32'(c == 0));
      chk($sformatf("b_fill%0d_ae", c),    32'(b_almostempty), 32'(c == 1 || c == 2));
      chk($sformatf("b_fill%0d_af", c),    32'(b_almostfull),  32'(c == 3 || c == 4));
      chk($sformatf("b_fill%0d_full", c),  32'(b_full),        32'(c == 5));
    end
    for (int k = 0; k < 20; k++) begin
      logic        w, r, aw, ar;
      logic [15:0] d, e;
      w  = (k % 4) != 3;
      r  = (k % 4) != 0;
      d  = 16'(32'h300 + k);
      aw = w && (q.size() != 5);
      ar = r && (q.size() != 0);
      e  = '0;
      if (ar) e = q.pop_front();
      if (aw) q.push_back(d);
      step(0,0,w,r,d);
      chk($sformatf("b_op%0d_cnt", k), 32'(b_count),     32'(q.size()));
      chk($sformatf("b_op%0d_ovf", k), 32'(b_overflow),  32'(w && !aw));
      chk($sformatf("b_op%0d_ack", k), 32'(b_wr_ack),    32'(aw));
      if (ar) chk($sformatf("b_op%0d_dout", k), 32'(b_data_out), 32'(e));
    end

    // ---------------- DUT C: FWFT ----------------
    step(1,0,0,0,16'h0000);
    chk("c_rst_dout",  32'(c_data_out), 32'h0);
    chk("c_rst_empty", 32'(c_empty),    32'h1);
    step(0,0,1,0,16'hA5A5);
    chk("c_wr1_dout",  32'(c_data_out), 32'hA5A5);
    chk("c_wr1_cnt",   32'(c_count),    32'd1);
    step(0,0,0,0,16'h0000);
    chk("c_idle_dout", 32'(c_data_out), 32'hA5A5);
    step(0,0,1,0,16'h1234);
    chk("c_wr2_dout",  32'(c_data_out), 32'hA5A5);
    chk("c_wr2_cnt",   32'(c_count),    32'd2);
    step(0,0,0,1,16'h0000);
    chk("c_rd1_dout",  32'(c_data_out), 32'h1234);
    chk("c_rd1_cnt",   32'(c_count),    32'd1);
    step(0,0,0,1,16'h0000);
    chk("c_rd2_dout",  32'(c_data_out), 32'h0);
    chk("c_rd2_empty", 32'(c_empty),    32'h1);
    step(0,0,1,0,16'hBEEF);
    chk("c_wr3_dout",  32'(c_data_out), 32'hBEEF);
    step(0,1,1,1,16'h7777);
    chk("c_flush_dout",  32'(c_data_out), 32'h0);
    chk("c_flush_empty", 32'(c_empty),    32'h1);
    chk("c_flush_ack",   32'(c_wr_ack),   32'h0);

    step(0,0,0,0,16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
